// File: rtl/serial_sub.sv
// serial_sub: bit-serial 8-bit subtractor D = A - B - Bi, LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output V.
module serial_sub (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Bi,
    output logic [7:0] D,
    output logic       Bo,
    output logic       BUSY,
`ifdef SERIAL_SUB_OVF_EN
    output logic       V,
`endif
    output logic       DONE
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2;
    logic [1:0] state;
    logic [7:0] sa, sb;
    logic [2:0] cnt;
    logic       bw, d_bit, bw_next;
    assign d_bit   = sa[0] ^ sb[0] ^ bw;
    assign bw_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bw);
    assign Bo      = bw;
    assign BUSY    = state == RUN;
    assign DONE    = state == FIN;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            sa    <= 8'h00;
            sb    <= 8'h00;
            D     <= 8'h00;
            cnt   <= 3'd0;
            bw    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            V     <= 1'b0;
`endif
        end else if (state == RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            D     <= {d_bit, D[7:1]};
            bw    <= bw_next;
            cnt   <= cnt + 3'd1;
            state <= cnt == 3'd7 ? FIN : RUN;
`ifdef SERIAL_SUB_OVF_EN
            // borrow into the sign bit vs borrow out of it
            if (cnt == 3'd7) V <= bw ^ bw_next;
`endif
        end else if (START) begin
            sa    <= A;
            sb    <= B;
            bw    <= Bi;
            cnt   <= 3'd0;
            state <= RUN;
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: scoreboard bench for serial_sub; directed vectors with hand-computed results.
module tb_serial_sub;
    logic       CLK = 1'b0, RST = 1'b1, START = 1'b0, Bi = 1'b0;
    logic [7:0] A = 8'h00, B = 8'h00, D;
    logic       Bo, BUSY, DONE, vv;
    int         checks = 0, errors = 0;
    logic [9:0] exp_q[$];

    always #5 CLK = ~CLK;

`ifdef SERIAL_SUB_OVF_EN
    logic V;
    assign vv = V;
    serial_sub dut (.CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .Bi(Bi),
                    .D(D), .Bo(Bo), .BUSY(BUSY), .V(V), .DONE(DONE));
    localparam bit OVF = 1'b1;
`else
    assign vv = 1'b0;
    serial_sub dut (.CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .Bi(Bi),
                    .D(D), .Bo(Bo), .BUSY(BUSY), .DONE(DONE));
    localparam bit OVF = 1'b0;
`endif

    always @(negedge CLK) begin
        if (!RST && DONE) begin
            logic [9:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got D=%h Bo=%b V=%b, no result expected", D, Bo, vv);
            end else begin
                e = exp_q.pop_front();
                if ({D, Bo, vv} !== e) begin
                    errors++;
                    $display("FAIL result: got D=%h Bo=%b V=%b, expected D=%h Bo=%b V=%b",
                             D, Bo, vv, e[9:2], e[1], e[0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic bi,
                         input logic [7:0] d, input logic bo, input logic v, input bit push);
        @(negedge CLK);
        A = a; B = b; Bi = bi; START = 1'b1;
        if (push) exp_q.push_back({d, bo, v & OVF});
        @(posedge CLK);
        #1 START = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
            if (n == 1) chk("busy_in_run", BUSY, 1);
        end while (!DONE && n < 30);
        if (!DONE) begin
            errors++;
            $display("FAIL done_timeout: got no DONE within %0d cycles, expected DONE", n);
        end
    endtask

    typedef struct { logic [7:0] a, b; logic bi; logic [7:0] d; logic bo, v; } vec_t;
    vec_t vecs[7] = '{
        '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0},
        '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0},
        '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0},
        '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0},
        '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1},
        '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1},
        '{8'hA5, 8'h3C, 1'b1, 8'h68, 1'b0, 1'b1}
    };

    initial begin
        int n;
        bit saw;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset_D", D, 8'h00);
        chk("reset_Bo", Bo, 0);
        chk("reset_BUSY", BUSY, 0);
        chk("reset_DONE", DONE, 0);
        RST = 1'b0;
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].d, vecs[i].bo, vecs[i].v, 1);
            wait_done(n);
            chk("latency", n, 9);
            @(negedge CLK);
            chk("held_D_idle", D, vecs[i].d);
            chk("done_one_cycle", DONE, 0);
        end
        // START during RUN must be ignored
        issue(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1);
        repeat (4) @(negedge CLK);
        A = 8'h30; B = 8'h10; Bi = 1'b1; START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        wait_done(n);
        chk("latency_ignore_start", n, 5);
        // reset mid-RUN aborts with no DONE
        issue(8'hF0, 8'h0F, 1'b0, 8'h00, 1'b0, 1'b0, 0);
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("abort_D", D, 8'h00);
        chk("abort_BUSY", BUSY, 0);
        chk("abort_Bo", Bo, 0);
        saw = 0;
        repeat (12) begin
            @(negedge CLK);
            if (DONE) saw = 1;
        end
        chk("abort_no_done", saw, 0);
        // back-to-back: START in the DONE cycle
        issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1);
        wait_done(n);
        A = 8'h7F; B = 8'hFF; Bi = 1'b0; START = 1'b1;
        exp_q.push_back({8'h80, 1'b1, OVF});
        @(posedge CLK);
        #1 START = 1'b0;
        wait_done(n);
        chk("back_to_back_gap", n, 9);
        repeat (12) @(negedge CLK);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port START, input, 1 bit: request a new subtraction; sampled on rising CLK.
REQ-004 SHALL have port A, input, 8 bits: minuend, captured when START is accepted.
REQ-005 SHALL have port B, input, 8 bits: subtrahend, captured when START is accepted.
REQ-006 SHALL have port Bi, input, 1 bit: borrow-in, captured when START is accepted.
REQ-007 SHALL have port D, output, 8 bits: difference A - B - Bi, modulo 256.
REQ-008 SHALL have port Bo, output, 1 bit: final borrow-out; 1 when A < B + Bi (unsigned).
REQ-009 SHALL have port BUSY, output, 1 bit: high while a subtraction is in progress.
REQ-010 SHALL have port DONE, output, 1 bit: one-cycle pulse marking D/Bo valid.

Function
REQ-011 SHALL be a bit-serial subtractor: one full-subtractor cell plus one borrow flip-flop, processing one bit per cycle, LSB first.
REQ-012 SHALL implement the per-bit cell as d = a XOR b XOR bw, bw_next = (NOT a AND b) OR (NOT (a XOR b) AND bw).
REQ-013 SHALL have three states: IDLE, RUN, DONE.
REQ-014 SHALL accept START in IDLE or DONE: on that edge load the A and B shift registers, set the borrow FF to Bi, clear the 3-bit bit counter, and go to RUN.
REQ-015 SHALL in RUN shift one result bit into D's shift register per edge, update the borrow FF, and increment the counter.
REQ-016 SHALL leave RUN for DONE on the edge that processes bit 7 (8 RUN edges total).
REQ-017 SHALL assert DONE for exactly the one cycle in state DONE, then go to IDLE unless START is high.
REQ-018 SHALL latency: START sampled at edge k gives DONE high during the cycle after edge k+8.
REQ-019 SHALL hold BUSY high exactly while in RUN.
REQ-020 SHALL ignore START while in RUN; operands are not re-captured.
REQ-021 SHALL hold D and Bo stable from DONE until the next accepted START. D is undefined for use while BUSY.
REQ-022 SHALL accept START in the DONE cycle for back-to-back operation, with no idle cycle in between.

Reset
REQ-023 SHALL on RST high at a rising edge enter IDLE and set D=0x00, Bo=0, BUSY=0, DONE=0, counter=0 and borrow FF=0 (V=0 when present).
REQ-024 SHALL give RST priority over START; reset mid-RUN aborts the operation and produces no DONE.

Configuration
REQ-025 SHALL, when macro SERIAL_SUB_OVF_EN is defined, add output port V, 1 bit: signed two's-complement overflow, computed as the borrow into bit 7 XOR the borrow out of bit 7; it is valid and held like Bo.
REQ-026 SHALL, when SERIAL_SUB_OVF_EN is undefined, have no V port and no overflow logic; all other behaviour is identical.

Verification
REQ-027 SHALL cover: A=0x05, B=0x03, Bi=0, START one cycle -> DONE 9 cycles later, D=0x02, Bo=0.
REQ-028 SHALL cover: A=0x03, B=0x05, Bi=0 -> D=0xFE, Bo=1; with OVF_EN, V=0.
REQ-029 SHALL cover: A=0x00, B=0x00, Bi=1 -> D=0xFF, Bo=1; A=0xFF, B=0xFF, Bi=0 -> D=0x00, Bo=0.
REQ-030 SHALL cover: with OVF_EN, A=0x80, B=0x01 -> D=0x7F, Bo=0, V=1; A=0x7F, B=0xFF -> D=0x80, Bo=1, V=1.
REQ-031 SHALL cover: START pulsed with new operands during RUN (cycle 4) -> ignored, result of the first operands only, one DONE.
REQ-032 SHALL cover: RST at RUN cycle 5 -> next cycle IDLE, D=0x00, BUSY=0, no DONE; then back-to-back START at the DONE cycle -> second DONE exactly 9 cycles after the first.
